// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment scanner: blanking, leading-zero suppression, frame snapshot.
// Optional macro SEG_DIM_EN adds a 4-bit PWM brightness input "dim".
module seg_scan_display #(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned DIV        = 50000,
    parameter int unsigned BLANK      = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
`ifdef SEG_DIM_EN
    input  logic [3:0]            dim,
`endif
    output logic [7:0]            SEG,
    output logic [DIGITS-1:0]     AN,
    output logic                  frame_tick
);

    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]     BLANK_END = CW'(BLANK);
    localparam logic [PW-1:0]     POS_LAST  = PW'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF   = {8{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{ACTIVE_LOW}};

    logic [CW-1:0]       r_cnt;
    logic [PW-1:0]       r_pos;
    logic [4*DIGITS-1:0] r_data;
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_blank;
    logic                r_tick;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic                w_cnt_wrap;
    logic                w_frame;
    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_supp;
    logic                w_zero_run;
    logic                w_lit;
    logic [7:0]          w_seg_al;
    logic [7:0]          w_seg_nxt;
    logic [DIGITS-1:0]   w_an_nxt;

`ifdef SEG_DIM_EN
    logic [3:0]          r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pwm <= '0;
        else        r_pwm <= r_pwm + 4'd1;
    end
`endif

    // Segment patterns g..a, active-low
    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'h0: dec7 = 7'h40;
            4'h1: dec7 = 7'h79;
            4'h2: dec7 = 7'h24;
            4'h3: dec7 = 7'h30;
            4'h4: dec7 = 7'h19;
            4'h5: dec7 = 7'h12;
            4'h6: dec7 = 7'h02;
            4'h7: dec7 = 7'h78;
            4'h8: dec7 = 7'h00;
            4'h9: dec7 = 7'h10;
            4'hA: dec7 = 7'h08;
            4'hB: dec7 = 7'h03;
            4'hC: dec7 = 7'h46;
            4'hD: dec7 = 7'h21;
            4'hE: dec7 = 7'h06;
            default: dec7 = 7'h0E;
        endcase
    endfunction

    assign w_cnt_wrap = (r_cnt == CNT_LAST);
    assign w_frame    = w_cnt_wrap && (r_pos == POS_LAST);
    assign w_nib      = r_data[4*r_pos +: 4];

    // Walk from the top digit down; a digit is suppressed while every digit above it is zero too
    always_comb begin
        w_supp     = '0;
        w_zero_run = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            w_zero_run              = w_zero_run && (r_data[4*(DIGITS-1-j) +: 4] == 4'd0);
            w_supp[DIGITS-1-j]      = lz_en && w_zero_run && ((DIGITS-1-j) != 0);
        end
    end

    always_comb begin
        w_lit     = 1'b0;
        w_seg_al  = 8'hFF;
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_OFF;
        if (en && (r_cnt >= BLANK_END) && !r_blank[r_pos]) begin
            if (!w_supp[r_pos]) begin
                w_lit    = 1'b1;
                w_seg_al = {~r_dp[r_pos], dec7(w_nib)};
            end else if (r_dp[r_pos]) begin
                w_lit    = 1'b1;
                w_seg_al = 8'h7F;
            end
        end
`ifdef SEG_DIM_EN
        if (r_pwm > dim) w_lit = 1'b0;
`endif
        if (w_lit) begin
            w_an_nxt  = AN_OFF ^ (DIGITS'(1) << r_pos);
            w_seg_nxt = ACTIVE_LOW ? w_seg_al : ~w_seg_al;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_pos   <= '0;
            r_data  <= '0;
            r_dp    <= '0;
            r_blank <= '0;
            r_tick  <= 1'b0;
            r_seg   <= SEG_OFF;
            r_an    <= AN_OFF;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
            if (!en) begin
                r_cnt   <= '0;
                r_pos   <= '0;
                r_data  <= data;
                r_dp    <= dp;
                r_blank <= blank;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= w_frame;
                r_cnt  <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
                if (w_cnt_wrap)
                    r_pos <= (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
                if (w_frame) begin
                    r_data  <= data;
                    r_dp    <= dp;
                    r_blank <= blank;
                end
            end
        end
    end

    assign SEG        = r_seg;
    assign AN         = r_an;
    assign frame_tick = r_tick;

endmodule
